// File: rtl/slot_sequencer_pkg.sv
// Shared definitions for the slot sequencer: FSM encoding, fault codes and the
// thermometer code used to predict which slots should already be set.
package slot_sequencer_pkg;

    localparam int MAX_SLOTS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } seq_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_STUCK   = 3'd1,
        ERR_SKIP    = 3'd2,
        ERR_DROP    = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_code_t;

    // Low n bits set, the rest clear.
    function automatic logic [MAX_SLOTS-1:0] therm(input logic [4:0] n);
        logic [MAX_SLOTS-1:0] code;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            code[i] = (5'(i) < n);
        end
        return code;
    endfunction

endpackage

// File: rtl/slot_sequencer_if.sv
// Slot-chain bus: slot Q feedback in, role strobes / clear / condition bits out.
interface slot_sequencer_if #(
    parameter int N_SLOTS = 8
) ();

    logic [N_SLOTS-1:0] slot_q;
    logic [N_SLOTS-1:0] role_inicio;
    logic [N_SLOTS-1:0] role_intermedio;
    logic [N_SLOTS-1:0] role_final;
    logic               slot_clr;
    logic               in1;
    logic               in2;
    logic               in3;

    modport master (
        input  slot_q,
        output role_inicio, role_intermedio, role_final, slot_clr, in1, in2, in3
    );

    modport slave (
        output slot_q,
        input  role_inicio, role_intermedio, role_final, slot_clr, in1, in2, in3
    );

endinterface

// File: rtl/slot_sequencer_step_timer.sv
// Loadable down-counter that sticks at zero; expired is high whenever it sits at zero.
module slot_step_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/slot_sequencer.sv
// Sequences a chain of slots: clears them, then watches the Q bits fill in as a
// thermometer code, flagging stuck, skipped, dropped or stalled steps.
module slot_sequencer
    import slot_sequencer_pkg::*;
#(
    parameter int N_SLOTS      = 8,
    parameter int STEP_TIMEOUT = 255,
    parameter int CLR_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [2:0]       step_cond,
    slot_sequencer_if.master slots,
    output logic [3:0]       active_idx,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code
);

    localparam logic [4:0]         LAST_IDX   = 5'(N_SLOTS);
    localparam logic [3:0]         CLR_LOAD   = 4'(CLR_CYCLES - 1);
    localparam logic [15:0]        TIMER_LOAD = 16'(STEP_TIMEOUT - 1);
    localparam logic [N_SLOTS-1:0] ROLE_FIRST = N_SLOTS'(1);
    localparam logic [N_SLOTS-1:0] ROLE_LAST  = {1'b1, {(N_SLOTS-1){1'b0}}};
    localparam logic [N_SLOTS-1:0] ROLE_MID   = ~(ROLE_FIRST | ROLE_LAST);

    // Reset asserts immediately but releases two edges later, so a START held
    // across release cannot be seen on the first edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    seq_state_t         state, state_next;
    err_code_t          code_q, code_next;
    logic [4:0]         idx, idx_next;
    logic [3:0]         clr_cnt, clr_cnt_next;
    logic               timer_load, timer_clear, timer_expired;
    logic [N_SLOTS-1:0] exp_cur, exp_nxt;
    logic               slot_clr_q;
    logic [2:0]         in_q;
    logic [N_SLOTS-1:0] role_ini_q, role_mid_q, role_fin_q;

    assign exp_cur = N_SLOTS'(therm(idx));
    assign exp_nxt = N_SLOTS'(therm(idx + 5'd1));

    slot_step_timer #(.WIDTH(16)) u_timer (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .load       (timer_load),
        .clear      (timer_clear),
        .enable     (state == ST_RUN),
        .load_value (TIMER_LOAD),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            code_q  <= ERR_NONE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            code_q  <= code_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // An exact advance is tested first so it beats a timer expiring on the same edge.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        code_next    = code_q;
        clr_cnt_next = clr_cnt;
        timer_load   = 1'b0;
        timer_clear  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = CLR_LOAD;
                    idx_next     = '0;
                    code_next    = ERR_NONE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == '0) begin
                    state_next = ST_ARM;
                end else begin
                    clr_cnt_next = clr_cnt - 4'd1;
                end
            end
            ST_ARM: begin
                if (slots.slot_q == '0) begin
                    state_next = ST_RUN;
                    idx_next   = '0;
                    timer_load = 1'b1;
                end else begin
                    state_next = ST_FAULT;
                    code_next  = ERR_STUCK;
                end
            end
            ST_RUN: begin
                if (slots.slot_q == exp_nxt) begin
                    idx_next = idx + 5'd1;
                    if (idx + 5'd1 == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        timer_load = 1'b1;
                    end
                end else if ((slots.slot_q & ~exp_nxt) != '0) begin
                    state_next = ST_FAULT;
                    code_next  = ERR_SKIP;
                end else if ((~slots.slot_q & exp_cur) != '0) begin
                    state_next = ST_FAULT;
                    code_next  = ERR_DROP;
                end else if (timer_expired) begin
                    state_next = ST_FAULT;
                    code_next  = ERR_TIMEOUT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (stop) begin
            state_next   = ST_IDLE;
            idx_next     = '0;
            code_next    = ERR_NONE;
            clr_cnt_next = '0;
            timer_load   = 1'b0;
            timer_clear  = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            slot_clr_q <= 1'b0;
            in_q       <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            active_idx <= 4'd0;
            role_ini_q <= '0;
            role_mid_q <= '0;
            role_fin_q <= '0;
        end else begin
            slot_clr_q <= (state_next == ST_CLEAR);
            in_q       <= (state_next == ST_RUN) ? step_cond : 3'b000;
            busy       <= (state_next inside {ST_CLEAR, ST_ARM, ST_RUN});
            done       <= (state_next == ST_DONE);
            err        <= (state_next == ST_FAULT);
            active_idx <= (idx_next > 5'd15) ? 4'hF : idx_next[3:0];
            role_ini_q <= (state_next != ST_IDLE) ? ROLE_FIRST : '0;
            role_mid_q <= (state_next != ST_IDLE) ? ROLE_MID : '0;
            role_fin_q <= (state_next != ST_IDLE) ? ROLE_LAST : '0;
        end
    end

    assign err_code              = code_q;
    assign slots.slot_clr        = slot_clr_q;
    assign slots.in1             = in_q[0];
    assign slots.in2             = in_q[1];
    assign slots.in3             = in_q[2];
    assign slots.role_inicio     = role_ini_q;
    assign slots.role_intermedio = role_mid_q;
    assign slots.role_final      = role_fin_q;

endmodule

// File: tb/tb_slot_sequencer.sv
// Bench for slot_sequencer (4 slots, 10-cycle step timeout): per-cycle vector table
// through a scoreboard, then hand-written reset-during-run sequence.
`timescale 1ns/1ps
module tb_slot_sequencer;

    localparam int N = 4;
    localparam logic [11:0] ROLES_ON = {4'b0001, 4'b0110, 4'b1000};

    typedef struct {
        string      name;
        logic       start;
        logic       stop;
        logic [2:0] cond;
        logic [3:0] q;
        logic [3:0] idx;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] code;
        logic       clr;
        logic [2:0] in_bits;
        logic       roles;
    } vec_t;

    typedef struct {
        string       name;
        logic [25:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] step_cond = 3'b000;
    logic [3:0] active_idx;
    logic       busy, done, err;
    logic [2:0] err_code;

    int   n_compared = 0;
    int   n_mismatched = 0;
    vec_t vecs[$];
    sb_t  sb_q[$];

    slot_sequencer_if #(.N_SLOTS(N)) sif ();

    slot_sequencer #(
        .N_SLOTS      (N),
        .STEP_TIMEOUT (10),
        .CLR_CYCLES   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .step_cond  (step_cond),
        .slots      (sif),
        .active_idx (active_idx),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] th(input int n);
        return 4'((1 << n) - 1);
    endfunction

    function automatic logic [2:0] rc();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic void row(input string n, input logic st, input logic sp,
                                input logic [2:0] c, input logic [3:0] q, input logic [3:0] idx,
                                input logic b, input logic d, input logic e, input logic [2:0] code,
                                input logic clr, input logic [2:0] inb, input logic roles);
        vec_t v;
        v.name = n; v.start = st; v.stop = sp; v.cond = c; v.q = q;
        v.idx = idx; v.busy = b; v.done = d; v.err = e; v.code = code;
        v.clr = clr; v.in_bits = inb; v.roles = roles;
        vecs.push_back(v);
    endfunction

    function automatic void start_seq(input string tag, input logic [3:0] q);
        row({tag, "_start"}, 1'b1, 1'b0, 3'd0, q, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1);
        row({tag, "_clr2"},  1'b0, 1'b0, 3'd0, q, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1);
        row({tag, "_arm"},   1'b0, 1'b0, 3'd0, q, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    endfunction

    function automatic void run_row(input string n, input logic [3:0] q, input logic [3:0] idx);
        logic [2:0] c;
        c = rc();
        row(n, 1'b0, 1'b0, c, q, idx, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, c, 1'b1);
    endfunction

    function automatic void fault_row(input string n, input logic [3:0] q, input logic [3:0] idx,
                                      input logic [2:0] code);
        row(n, 1'b0, 1'b0, rc(), q, idx, 1'b0, 1'b0, 1'b1, code, 1'b0, 3'd0, 1'b1);
    endfunction

    function automatic void done_row(input string n);
        row(n, 1'b0, 1'b0, rc(), 4'hF, 4'd4, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    endfunction

    function automatic void build_table();
        // Normal run, one slot every 5 cycles
        start_seq("a", 4'h0);
        run_row("a_run", 4'h0, 4'd0);
        for (int s = 1; s <= 4; s++) begin
            for (int k = 0; k < 4; k++) run_row($sformatf("a_hold%0d", s), th(s - 1), 4'(s - 1));
            if (s < 4) run_row($sformatf("a_step%0d", s), th(s), 4'(s));
            else       done_row("a_done");
        end
        done_row("a_done_hold");
        // Stuck slot during ARM
        start_seq("b", 4'b0010);
        fault_row("b_stuck", 4'b0010, 4'd0, 3'd1);
        fault_row("b_stuck_hold", 4'b0010, 4'd0, 3'd1);
        // Skip: 0001 -> 0111
        start_seq("c", 4'h0);
        run_row("c_run", 4'h0, 4'd0);
        run_row("c_s1", 4'b0001, 4'd1);
        fault_row("c_skip", 4'b0111, 4'd1, 3'd2);
        // Drop: 0011 -> 0001
        start_seq("d", 4'h0);
        run_row("d_run", 4'h0, 4'd0);
        run_row("d_s1", 4'b0001, 4'd1);
        run_row("d_s2", 4'b0011, 4'd2);
        fault_row("d_drop", 4'b0001, 4'd2, 3'd3);
        // Timeout exactly 10 edges after entering RUN
        start_seq("e", 4'h0);
        run_row("e_run", 4'h0, 4'd0);
        for (int k = 1; k <= 9; k++) run_row($sformatf("e_wait%0d", k), 4'h0, 4'd0);
        fault_row("e_timeout", 4'h0, 4'd0, 3'd4);
        fault_row("e_timeout_hold", 4'h0, 4'd0, 3'd4);
        // Last bit arrives on the very edge the timer expires
        start_seq("f", 4'h0);
        run_row("f_run", 4'h0, 4'd0);
        for (int s = 1; s <= 3; s++) run_row($sformatf("f_s%0d", s), th(s), 4'(s));
        for (int k = 1; k <= 9; k++) run_row($sformatf("f_wait%0d", k), th(3), 4'd3);
        done_row("f_last_wins");
        // STOP beats START in RUN, then a lone START
        start_seq("g", 4'h0);
        run_row("g_run", 4'h0, 4'd0);
        run_row("g_s1", 4'b0001, 4'd1);
        row("g_stop_start", 1'b1, 1'b1, 3'd7, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        row("g_idle", 1'b0, 1'b0, 3'd7, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        start_seq("g2", 4'h0);
        row("g2_stop", 1'b0, 1'b1, 3'd5, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        // Run left in progress for the reset sequence
        start_seq("h", 4'h0);
        run_row("h_run", 4'h0, 4'd0);
        run_row("h_s1", 4'b0001, 4'd1);
    endfunction

    function automatic logic [25:0] pack_actual();
        return {active_idx, busy, done, err, err_code, sif.slot_clr, sif.in3, sif.in2, sif.in1,
                sif.role_inicio, sif.role_intermedio, sif.role_final};
    endfunction

    function automatic logic [25:0] pack_expected(input vec_t v);
        return {v.idx, v.busy, v.done, v.err, v.code, v.clr, v.in_bits,
                v.roles ? ROLES_ON : 12'h000};
    endfunction

    task automatic checkOutput();
        sb_t         e;
        logic [25:0] act;
        n_compared++;
        if (sb_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_empty: got output with no expected entry");
            return;
        end
        e   = sb_q.pop_front();
        act = pack_actual();
        if (act !== e.exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
    endtask

    task automatic push_expected(input string n, input logic [25:0] exp);
        sb_t e;
        e.name = n;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        start     = v.start;
        stop      = v.stop;
        step_cond = v.cond;
        sif.slot_q = v.q;
        push_expected(v.name, pack_expected(v));
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic expect_now(input string n, input logic [25:0] exp);
        push_expected(n, exp);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation ran too long, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen_busy;
        logic saw_flag;
        sif.slot_q = '0;
        build_table();
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset_state", '0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_now("post_release_idle", '0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Asynchronous reset in the middle of a run
        #2 rst_n = 1'b0;
        #1 expect_now("h_async_reset", '0);
        start = 1'b1;
        stop  = 1'b0;
        @(posedge clk);
        #1 expect_now("h_held_in_reset", '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 expect_now("h_release_edge1", '0);
        seen_busy = 1'b0;
        saw_flag  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done || err) saw_flag = 1'b1;
            if (busy) begin
                seen_busy = 1'b1;
                break;
            end
        end
        n_compared++;
        if (!seen_busy) begin
            n_mismatched++;
            $display("[TB] FAIL h_start_after_release: got busy=0 after 7 edges, expected busy=1");
        end
        n_compared++;
        if (saw_flag) begin
            n_mismatched++;
            $display("[TB] FAIL h_no_done_err: got done/err=1 after reset, expected 0");
        end
        start = 1'b0;
        stop  = 1'b1;
        @(posedge clk);
        #1 expect_now("h_stop", '0);
        stop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/slot_sequencer.md
SLOT_SEQUENCER -- requirements
Module: slot_sequencer

Interface
REQ-001 Parameter N_SLOTS, default 8, SHALL set the number of slots in the chain (range 3..16).
REQ-002 Parameter STEP_TIMEOUT, default 255, SHALL set the maximum cycles allowed per chain advance (range 1..65535).
REQ-003 Parameter CLR_CYCLES, default 2, SHALL set the slot-clear pulse length in cycles (range 1..15).
REQ-004 CLK  in  1  the single clock; all state SHALL be on its rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous and active-low.
REQ-006 START  in  1  sampled high: begin a run.
REQ-007 STOP  in  1  sampled high: abort to IDLE.
REQ-008 STEP_COND  in  3  live condition bits to broadcast to the slots.
REQ-009 SLOT_Q  in  N_SLOTS  Q output of each slot; bit 0 is the first slot.
REQ-010 ROLE_INICIO / ROLE_INTERMEDIO / ROLE_FINAL  out  N_SLOTS each  per-slot role strobes.
REQ-011 SLOT_CLR  out  1  drives every slot's RESET input.
REQ-012 IN1, IN2, IN3  out  1 each  broadcast condition bits.
REQ-013 ACTIVE_IDX  out  4  count of slots confirmed set.
REQ-014 BUSY, DONE, ERR  out  1 each  status levels.
REQ-015 ERR_CODE  out  3  fault cause.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, ARM, RUN, DONE and FAULT.
REQ-017 In IDLE, START SHALL move the FSM to CLEAR; all other inputs are ignored.
REQ-018 In CLEAR, SLOT_CLR SHALL be high for exactly CLR_CYCLES cycles, then the FSM SHALL go to ARM.
REQ-019 In ARM, SLOT_Q==0 SHALL move the FSM to RUN with ACTIVE_IDX=0.
REQ-020 In ARM, any other SLOT_Q value SHALL move the FSM to FAULT with ERR_CODE=1 (stuck).
REQ-021 In RUN, IN1..IN3 SHALL equal STEP_COND registered one cycle; outside RUN they SHALL be 0.
REQ-022 In RUN, expected SLOT_Q SHALL be the thermometer code with its low ACTIVE_IDX bits set.
REQ-023 In RUN, SLOT_Q equal to the thermometer code for ACTIVE_IDX+1 SHALL increment ACTIVE_IDX and clear the step timer in the same edge.
REQ-024 In RUN, a set bit above position ACTIVE_IDX SHALL cause FAULT with ERR_CODE=2 (skip).
REQ-025 In RUN, a clear bit below position ACTIVE_IDX SHALL cause FAULT with ERR_CODE=3 (drop).
REQ-026 In RUN, the step timer reaching STEP_TIMEOUT SHALL cause FAULT with ERR_CODE=4 (timeout); the timer SHALL saturate, never wrap.
REQ-027 When ACTIVE_IDX reaches N_SLOTS, the FSM SHALL go to DONE.
REQ-028 In the cycle that sets the last bit, the advance SHALL win over timeout.
REQ-029 DONE SHALL hold DONE=1; FAULT SHALL hold ERR=1 and ERR_CODE.
REQ-030 In DONE or FAULT, START SHALL go to CLEAR and clear DONE, ERR and ERR_CODE.
REQ-031 STOP SHALL force IDLE from any state on the next edge, with priority over START and over every other transition.
REQ-032 On STOP, ACTIVE_IDX, ERR_CODE and the timer SHALL clear.
REQ-033 BUSY SHALL be 1 in CLEAR, ARM and RUN only.
REQ-034 Outside IDLE, ROLE_INICIO SHALL be bit 0, ROLE_FINAL SHALL be bit N_SLOTS-1, and ROLE_INTERMEDIO SHALL be all other bits; in IDLE all role outputs SHALL be 0.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 RESET_N low SHALL asynchronously force IDLE and drive every output to 0.
REQ-037 Reset mid-run SHALL abandon the run with no DONE or ERR pulse.
REQ-038 Release of RESET_N SHALL be synchronous to CLK; the first START SHALL be honoured no earlier than the second edge after release.

Structure
REQ-039 A shared package SHALL hold the state encoding, the ERR_CODE constants (0 none, 1 stuck, 2 skip, 3 drop, 4 timeout) and the thermometer function.
REQ-040 One sub-module, slot_step_timer (a loadable, saturating down-counter with an expiry flag), SHALL implement the timeout.

Verification
REQ-041 N_SLOTS=4: START, then set SLOT_Q to 0001, 0011, 0111, 1111 at 5-cycle spacing -> ACTIVE_IDX steps 1..4, then DONE=1, ERR=0, BUSY=0.
REQ-042 SLOT_Q=0010 held during ARM -> FAULT, ERR=1, ERR_CODE=1, SLOT_CLR already deasserted.
REQ-043 In RUN with ACTIVE_IDX=1, SLOT_Q jumps from 0001 to 0111 -> ERR_CODE=2 on the next edge.
REQ-044 STEP_TIMEOUT=10 with no SLOT_Q change -> ERR_CODE=4 exactly 10 cycles after entering RUN.
REQ-045 STOP and START both high during RUN -> IDLE, ACTIVE_IDX=0, IN1..IN3=0; a later lone START pulses SLOT_CLR for 2 cycles.
REQ-046 RESET_N pulsed low mid-RUN -> all outputs 0 asynchronously, and DONE/ERR never assert.
